// File: rtl/vga_sram_pixel_writer_pkg.sv
// vga_sram_pixel_writer_pkg: shared VGA framebuffer geometry defaults and AXI response codes
//   H_VISIBLE_DEF / V_VISIBLE_DEF : framebuffer columns / rows
//   AXI_RESP_OKAY                 : the only bresp value treated as success
package vga_sram_pixel_writer_pkg;
    localparam int H_VISIBLE_DEF = 640;
    localparam int V_VISIBLE_DEF = 480;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/vga_sram_pixel_writer.sv
// vga_sram_pixel_writer: writes single {x,y,color} pixels into a framebuffer over AXI-Lite
//   clk, reset                          : clock, synchronous active-high reset
//   pixel_valid/ready, x, y, color      : pixel input handshake, 12-bit {r,g,b} colour
//   axi_aw* / axi_w* / axi_b*           : AXI-Lite write channels, one write outstanding at most
//   oob_drop                            : one-cycle pulse when an out-of-bounds pixel is consumed
//   write_err                           : sticky flag, set by any non-OKAY write response
module vga_sram_pixel_writer
    import vga_sram_pixel_writer_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int H_VISIBLE      = H_VISIBLE_DEF,
    parameter int V_VISIBLE      = V_VISIBLE_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pixel_valid,
    output logic                        pixel_ready,
    input  logic [9:0]                  pixel_x,
    input  logic [9:0]                  pixel_y,
    input  logic [11:0]                 pixel_color,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    output logic                        axi_awvalid,
    input  logic                        axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                        axi_wvalid,
    input  logic                        axi_wready,
    input  logic [1:0]                  axi_bresp,
    input  logic                        axi_bvalid,
    output logic                        axi_bready,
    output logic                        oob_drop,
    output logic                        write_err
);
    typedef enum logic [1:0] {IDLE, WRITE, RESP} state_e;

    state_e                      state_q, state_d;
    logic                        awvalid_q, awvalid_d;
    logic                        wvalid_q, wvalid_d;
    logic                        oob_q, oob_d;
    logic                        err_q, err_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0]   data_q, data_d;
    logic                        accept, oob, start, b_hs;

    assign accept = pixel_valid & pixel_ready;
    assign oob    = (32'(pixel_x) >= H_VISIBLE) || (32'(pixel_y) >= V_VISIBLE);
    assign start  = accept & ~oob;
    assign b_hs   = axi_bvalid & axi_bready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            oob_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            oob_q     <= oob_d;
            err_q     <= err_d;
        end
    end

    // Address/data need no reset: they are only observed while a valid is high.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    // WRITE ends once both valids have dropped, i.e. both handshakes are done.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start ? WRITE : IDLE;
            WRITE:   state_d = (!awvalid_q && !wvalid_q) ? RESP : WRITE;
            RESP:    state_d = b_hs ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        awvalid_d = start | (awvalid_q & ~axi_awready);
        wvalid_d  = start | (wvalid_q & ~axi_wready);
        addr_d    = start ? AXI_ADDR_WIDTH'(32'(pixel_y) * 32'(H_VISIBLE) + 32'(pixel_x)) : addr_q;
        data_d    = start ? AXI_DATA_WIDTH'({pixel_color, 4'b0000}) : data_q;
        oob_d     = accept & oob;
        err_d     = err_q | (b_hs & (axi_bresp != AXI_RESP_OKAY));
    end

    always_comb begin
        pixel_ready = (state_q == IDLE) & ~reset;
        axi_bready  = (state_q == RESP) & ~reset;
        axi_awvalid = awvalid_q & ~reset;
        axi_wvalid  = wvalid_q & ~reset;
        oob_drop    = oob_q & ~reset;
        write_err   = err_q & ~reset;
        axi_awaddr  = addr_q;
        axi_wdata   = data_q;
        axi_wstrb   = '1;
    end
endmodule

// File: tb/tb_vga_sram_pixel_writer.sv
// tb_vga_sram_pixel_writer: scoreboard bench for vga_sram_pixel_writer with a reactive AXI-Lite slave
module tb_vga_sram_pixel_writer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic [11:0] pixel_color = '0;
    logic [19:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready = 1'b0;
    logic [15:0] axi_wdata;
    logic [1:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready = 1'b0;
    logic [1:0]  axi_bresp = 2'b00;
    logic        axi_bvalid = 1'b0;
    logic        axi_bready;
    logic        oob_drop;
    logic        write_err;

    int checks = 0;
    int errors = 0;
    int aw_delay = 0, w_delay = 0;
    logic [1:0] bresp_sel = 2'b00;
    int aw_cnt = 0, w_cnt = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
    int last_aw_len = 0, last_w_len = 0;
    logic prev_awv = 0, prev_awhs = 0, prev_wv = 0, prev_whs = 0;
    logic [19:0] prev_addr = '0;
    logic [15:0] prev_data = '0;
    logic [19:0] exp_aw[$];
    logic [15:0] exp_w[$];

    vga_sram_pixel_writer dut (
        .clk(clk), .reset(reset),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .oob_drop(oob_drop), .write_err(write_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Slave model and scoreboard monitor: readies are decided at the negedge,
    // handshakes seen here complete at the following posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                aw_cnt = 0; w_cnt = 0;
                axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
                prev_awv = 0; prev_awhs = 0; prev_wv = 0; prev_whs = 0;
            end else begin
                aw_cnt = axi_awvalid ? aw_cnt + 1 : 0;
                w_cnt  = axi_wvalid ? w_cnt + 1 : 0;
                axi_awready = axi_awvalid && aw_cnt > aw_delay;
                axi_wready  = axi_wvalid && w_cnt > w_delay;
                axi_bvalid  = axi_bready;
                axi_bresp   = bresp_sel;
                if (axi_awvalid && prev_awv && !prev_awhs) chk("awaddr_stable", axi_awaddr, prev_addr);
                if (axi_wvalid && prev_wv && !prev_whs) chk("wdata_stable", axi_wdata, prev_data);
                if (axi_awvalid && axi_awready) begin
                    if (exp_aw.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL aw_unexpected: got awaddr %0h, expected no AW handshake", axi_awaddr);
                    end else chk("awaddr", axi_awaddr, exp_aw.pop_front());
                    last_aw_len = aw_cnt;
                    aw_hs++;
                end
                if (axi_wvalid && axi_wready) begin
                    if (exp_w.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL w_unexpected: got wdata %0h, expected no W handshake", axi_wdata);
                    end else chk("wdata", axi_wdata, exp_w.pop_front());
                    chk("wstrb", axi_wstrb, 2'b11);
                    last_w_len = w_cnt;
                    w_hs++;
                end
                if (axi_bvalid && axi_bready) b_hs++;
                prev_awv = axi_awvalid; prev_awhs = axi_awvalid && axi_awready; prev_addr = axi_awaddr;
                prev_wv = axi_wvalid; prev_whs = axi_wvalid && axi_wready; prev_data = axi_wdata;
            end
        end
    end

    task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [11:0] c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pixel_ready && n < 100);
        if (!pixel_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: got pixel_ready 0, expected 1 within 100 cycles");
        end
        pixel_x = x; pixel_y = y; pixel_color = c; pixel_valid = 1'b1;
        @(posedge clk);
        #1 pixel_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pixel_ready && n < 100);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n, b0;
        repeat (3) @(negedge clk);
        chk("rst_pixel_ready", pixel_ready, 0);
        chk("rst_awvalid", axi_awvalid, 0);
        chk("rst_wvalid", axi_wvalid, 0);
        chk("rst_bready", axi_bready, 0);
        chk("rst_oob_drop", oob_drop, 0);
        chk("rst_write_err", write_err, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", pixel_ready, 1);

        // basic write, all readies immediate
        b0 = b_hs;
        exp_aw.push_back(20'd1283); exp_w.push_back(16'hF0A0);
        send(10'd3, 10'd2, 12'hF0A);
        wait_ready(n);
        chk("s1_ready_latency", n, 4);
        chk("s1_awvalid_len", last_aw_len, 1);
        chk("s1_wvalid_len", last_w_len, 1);
        chk("s1_b_count", b_hs - b0, 1);

        // awready delayed 5 cycles, wready immediate
        aw_delay = 5; b0 = b_hs;
        exp_aw.push_back(20'd650); exp_w.push_back(16'h1230);
        send(10'd10, 10'd1, 12'h123);
        wait_ready(n);
        chk("s2_ready_latency", n, 9);
        chk("s2_awvalid_len", last_aw_len, 6);
        chk("s2_wvalid_len", last_w_len, 1);
        chk("s2_b_count", b_hs - b0, 1);
        aw_delay = 0;

        // out-of-bounds column and row
        b0 = aw_hs;
        send(10'd640, 10'd0, 12'hABC);
        @(negedge clk);
        chk("s3_oob_pulse", oob_drop, 1);
        chk("s3_ready_next", pixel_ready, 1);
        chk("s3_no_awvalid", axi_awvalid, 0);
        @(negedge clk);
        chk("s3_oob_single", oob_drop, 0);
        send(10'd0, 10'd480, 12'hABC);
        @(negedge clk);
        chk("s3_oob_row", oob_drop, 1);
        @(negedge clk);
        chk("s3_no_aw_hs", aw_hs - b0, 0);

        // error response on the second of three writes
        exp_aw.push_back(20'd0); exp_w.push_back(16'hFFF0);
        send(10'd0, 10'd0, 12'hFFF);
        wait_ready(n);
        chk("s4_err_after_ok", write_err, 0);
        bresp_sel = 2'b10;
        exp_aw.push_back(20'd64005); exp_w.push_back(16'h5A50);
        send(10'd5, 10'd100, 12'h5A5);
        wait_ready(n);
        chk("s4_err_set", write_err, 1);
        bresp_sel = 2'b00;
        exp_aw.push_back(20'd639); exp_w.push_back(16'h0010);
        send(10'd639, 10'd0, 12'h001);
        wait_ready(n);
        chk("s4_err_sticky", write_err, 1);
        do_reset(2);
        chk("s4_err_cleared", write_err, 0);

        // reset in the middle of WRITE
        aw_delay = 20; w_delay = 20;
        send(10'd7, 10'd7, 12'h777);
        @(negedge clk);
        chk("s5_awvalid_pending", axi_awvalid, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("s5_awvalid_cleared", axi_awvalid, 0);
        chk("s5_wvalid_cleared", axi_wvalid, 0);
        chk("s5_bready_cleared", axi_bready, 0);
        chk("s5_ready_in_rst", pixel_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        aw_delay = 0; w_delay = 0;
        @(negedge clk);
        chk("s5_err_clean", write_err, 0);
        b0 = b_hs;
        exp_aw.push_back(20'd307199); exp_w.push_back(16'h8420);
        send(10'd639, 10'd479, 12'h842);
        wait_ready(n);
        chk("s5_ready_latency", n, 4);
        chk("s5_b_count", b_hs - b0, 1);

        chk("total_aw_hs", aw_hs, 6);
        chk("total_w_hs", w_hs, 6);
        chk("aw_queue_empty", exp_aw.size(), 0);
        chk("w_queue_empty", exp_w.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1);
    end
endmodule

// File: doc/vga_sram_pixel_writer.md
VGA_SRAM_PIXEL_WRITER -- requirements
Module: vga_sram_pixel_writer

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 20, meaning the framebuffer word address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 16, meaning the framebuffer word width.
REQ-003 SHALL have parameter H_VISIBLE, default 640, meaning the framebuffer columns.
REQ-004 SHALL have parameter V_VISIBLE, default 480, meaning the framebuffer rows.
REQ-005 SHALL have port clk  in  1  system clock; all logic on the rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have pixel-input ports: pixel_valid in 1; pixel_ready out 1; pixel_x in 10 (column); pixel_y in 10 (row); pixel_color in 12 ({r[3:0],g[3:0],b[3:0]}).
REQ-008 SHALL have AXI-Lite write address ports: axi_awaddr out AXI_ADDR_WIDTH; axi_awvalid out 1; axi_awready in 1.
REQ-009 SHALL have AXI-Lite write data ports: axi_wdata out AXI_DATA_WIDTH; axi_wstrb out AXI_DATA_WIDTH/8; axi_wvalid out 1; axi_wready in 1.
REQ-010 SHALL have AXI-Lite write response ports: axi_bresp in 2; axi_bvalid in 1; axi_bready out 1.
REQ-011 SHALL have status ports: oob_drop out 1 (one-cycle pulse, out-of-bounds pixel dropped); write_err out 1 (sticky, non-OKAY bresp seen).

Function
REQ-012 SHALL implement states IDLE, WRITE, RESP.
REQ-013 SHALL drive pixel_ready = 1 only in IDLE and only while reset is low.
REQ-014 SHALL define an accept as pixel_valid & pixel_ready.
REQ-015 SHALL compute the address as pixel_y*H_VISIBLE + pixel_x in AXI_ADDR_WIDTH bits; 479*640+639 = 307199 SHALL fit the 20-bit default without truncation.
REQ-016 SHALL pack the data as {pixel_color, 4'b0000}, so that red lands in [15:12], green in [11:8] and blue in [7:4]; axi_wstrb SHALL be all ones.
REQ-017 On an accept with pixel_x >= H_VISIBLE or pixel_y >= V_VISIBLE, SHALL consume the pixel, pulse oob_drop the next cycle, stay in IDLE and issue no AXI traffic.
REQ-018 On an in-bounds accept, SHALL register the address and data, then assert axi_awvalid and axi_wvalid together the next cycle and enter WRITE.
REQ-019 In WRITE, SHALL clear axi_awvalid the cycle after axi_awready&axi_awvalid, and clear axi_wvalid the cycle after axi_wready&axi_wvalid, independently and in either order.
REQ-020 SHALL hold axi_awaddr and axi_wdata stable while the corresponding valid is high.
REQ-021 SHALL enter RESP once both handshakes have completed, including both in the same cycle, and SHALL never re-assert a valid for the same pixel.
REQ-022 SHALL assert axi_bready only in RESP.
REQ-023 On axi_bvalid&axi_bready, SHALL return to IDLE; if axi_bresp != 2'b00, write_err SHALL be set and held until reset.
REQ-024 SHALL re-assert pixel_ready the cycle after the B handshake; minimum accept-to-accept spacing is 4 cycles when awready, wready and bvalid respond immediately.
REQ-025 SHALL keep at most one write outstanding at any time.

Reset
REQ-026 While reset is high, the block SHALL enter IDLE and drive pixel_ready, axi_awvalid, axi_wvalid, axi_bready, oob_drop and write_err to 0.
REQ-027 A reset asserted mid-transaction SHALL abandon the write immediately, with no completion or error reported.
REQ-028 axi_awaddr and axi_wdata have no reset value and are don't-care while their valids are low.

Structure
REQ-029 The shared VGA include SHALL hold the H_VISIBLE/V_VISIBLE defaults and the AXI response codes (OKAY=2'b00); the state encodings SHALL stay local to the module.
REQ-030 The block SHALL be a single module with no sub-module; address arithmetic is done inline.

Verification
REQ-031 Bench SHALL cover: pixel (x=3,y=2,color=12'hF0A), all readies high -> awaddr=1283 and wdata=16'hF0A0, both valids high for exactly 1 cycle, pixel_ready back 4 cycles after the accept.
REQ-032 Bench SHALL cover: awready delayed 5 cycles with wready immediate -> wvalid drops after 1 cycle, awvalid holds a stable address for 5 cycles, then exactly one B handshake follows.
REQ-033 Bench SHALL cover: pixel (x=640,y=0) -> oob_drop pulses for 1 cycle, no awvalid, pixel_ready high the next cycle.
REQ-034 Bench SHALL cover: bresp=2'b10 on the second of three writes -> write_err rises after that handshake, stays high through the third write, and clears only on reset.
REQ-035 Bench SHALL cover: reset asserted while in WRITE with awvalid high -> all valids are 0 the next cycle, a new pixel is accepted after reset, and the corner pixel (639,479) produces awaddr=307199.
